// File: rtl/sipo_deser_pkg.sv
// Shared definitions for the serial-in parallel-out receiver.
// Optional feature macro: SIPO_PARITY_EN (adds one even-parity bit per frame).
package sipo_deser_pkg;

    // Bit-order and parity conventions shared with the transmitter end of the link
    localparam int unsigned SR_DEFAULT_WIDTH = 4;
    localparam bit          SR_MSB_FIRST     = 1'b1;
    localparam bit          SR_PARITY_EVEN   = 1'b0;

`ifdef SIPO_PARITY_EN
    localparam int unsigned PARITY_BITS = 1;
`else
    localparam int unsigned PARITY_BITS = 0;
`endif

    // Receiver phase, decoded from the bit counter
    typedef enum logic {
        StIdle,
        StRecv
    } rx_state_e;

    // Number of serial bits that make up one frame
    function automatic int unsigned frame_len(input int unsigned width);
        return width + PARITY_BITS;
    endfunction

endpackage

// File: rtl/sipo_bitcnt.sv
// Mod-FRAME bit counter for the SIPO receiver: advances on en, sync clear, async active-low reset.
module sipo_bitcnt #(
    parameter int unsigned FRAME = 4,
    parameter int unsigned CW    = $clog2(FRAME)
) (
    input  logic          clk,
    input  logic          reset_,
    input  logic          clear,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          last
);

    localparam logic [CW-1:0] CntLast = CW'(FRAME - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: clear wins, wrap after the final bit of the frame
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + CW'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign last = (cnt_q == CntLast);

endmodule

// File: rtl/sipo_deser.sv
// Serial-in parallel-out receiver: assembles WIDTH-bit words from a serial stream and
// delivers them through a one-entry valid/ready holding register.
// Optional feature macro: SIPO_PARITY_EN (frame carries a trailing even-parity bit).
module sipo_deser
    import sipo_deser_pkg::*;
#(
    parameter int unsigned WIDTH = SR_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic             clear,
    input  logic             sin,
    input  logic             sin_valid,
    output logic [WIDTH-1:0] pout,
    output logic             pout_valid,
    input  logic             pout_ready,
    output logic             busy,
    output logic             overrun,
    output logic             parity_err
);

    localparam int unsigned FRAME = frame_len(WIDTH);
    localparam int unsigned CW    = $clog2(FRAME);

    logic [CW-1:0]    cnt;
    logic             cnt_last;
    logic             complete;
    logic             data_bit;
    logic [WIDTH-1:0] sr_shift;
    logic [WIDTH-1:0] word_new;
    logic             perr_new;
    rx_state_e        state;

    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] pout_q, pout_d;
    logic             pout_valid_q, pout_valid_d;
    logic             overrun_q, overrun_d;

    sipo_bitcnt #(
        .FRAME (FRAME),
        .CW    (CW)
    ) u_bitcnt (
        .clk    (clk),
        .reset_ (reset_),
        .clear  (clear),
        .en     (sin_valid),
        .cnt    (cnt),
        .last   (cnt_last)
    );

    // Phase decode; the counter itself is the frame state
    always_comb begin
        state = (cnt != '0) ? StRecv : StIdle;
        busy  = (state == StRecv);
    end

    // Word assembly: shift path, completed word and its parity result
    always_comb begin
        sr_shift = SR_MSB_FIRST ? {sr_q[WIDTH-2:0], sin} : {sin, sr_q[WIDTH-1:1]};
        complete = sin_valid & cnt_last & ~clear;
`ifdef SIPO_PARITY_EN
        // Parity bit occupies the slot after the data bits and never enters sr
        data_bit = (cnt != CW'(WIDTH));
        word_new = sr_q;
        perr_new = (^{sr_q, sin}) ^ SR_PARITY_EVEN;
`else
        data_bit = 1'b1;
        word_new = sr_shift;
        perr_new = 1'b0;
`endif
    end

    // Shift register next state: clear flushes, idle cycles freeze
    always_comb begin
        sr_d = sr_q;
        if (clear) begin
            sr_d = '0;
        end else if (sin_valid && data_bit) begin
            sr_d = sr_shift;
        end
    end

    // Holding register, valid flag and sticky overrun
    always_comb begin
        pout_d       = pout_q;
        pout_valid_d = pout_valid_q;
        overrun_d    = overrun_q;
        if (clear) begin
            pout_valid_d = 1'b0;
            overrun_d    = 1'b0;
        end else if (complete) begin
            if (!pout_valid_q || pout_ready) begin
                // Back-to-back load keeps valid high across the handshake
                pout_d       = word_new;
                pout_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (pout_valid_q && pout_ready) begin
            pout_valid_d = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            sr_q         <= '0;
            pout_q       <= '0;
            pout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sr_q         <= sr_d;
            pout_q       <= pout_d;
            pout_valid_q <= pout_valid_d;
            overrun_q    <= overrun_d;
        end
    end

`ifdef SIPO_PARITY_EN
    logic perr_q, perr_d;

    // Parity flag travels with the word into the holding register
    always_comb begin
        perr_d = perr_q;
        if (complete && (!pout_valid_q || pout_ready)) begin
            perr_d = perr_new;
        end
    end

    // Parity flag register
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign parity_err = perr_q;
`else
    logic unused_perr;
    assign unused_perr = perr_new;
    assign parity_err  = 1'b0;
`endif

    assign pout       = pout_q;
    assign pout_valid = pout_valid_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_sipo_deser.sv
// Self-checking bench for sipo_deser (WIDTH=4): table-driven cycle vectors plus
// hand-written reset/clear abort and parity sequences.
module tb_sipo_deser;

    logic       clk = 1'b0;
    logic       reset_;
    logic       clear;
    logic       sin;
    logic       sin_valid;
    logic [3:0] pout;
    logic       pout_valid;
    logic       pout_ready;
    logic       busy;
    logic       overrun;
    logic       parity_err;

    int total = 0;
    int bad   = 0;

    sipo_deser #(
        .WIDTH (4)
    ) dut (
        .clk        (clk),
        .reset_     (reset_),
        .clear      (clear),
        .sin        (sin),
        .sin_valid  (sin_valid),
        .pout       (pout),
        .pout_valid (pout_valid),
        .pout_ready (pout_ready),
        .busy       (busy),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    // One cycle of stimulus and the outputs expected right after the following edge
    typedef struct {
        logic       clr;
        logic       sin;
        logic       sv;
        logic       rdy;
        logic       chk_pout;
        logic [3:0] pout;
        logic       pv;
        logic       busy;
        logic       ovr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic clr, logic s, logic sv, logic rdy, logic chk,
                                logic [3:0] p, logic pv, logic b, logic o);
        vec_t v;
        v.clr = clr; v.sin = s; v.sv = sv; v.rdy = rdy; v.chk_pout = chk;
        v.pout = p; v.pv = pv; v.busy = b; v.ovr = o;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic clr, input logic s, input logic sv, input logic rdy);
        @(negedge clk);
        clear      = clr;
        sin        = s;
        sin_valid  = sv;
        pout_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    // Sends one 4-bit word MSB first, ready held at rdy, on consecutive cycles
    task automatic send_word(input logic [3:0] w, input logic rdy);
        for (int i = 3; i >= 0; i--) begin
            drive(1'b0, w[i], 1'b1, rdy);
        end
    endtask

    initial begin
        reset_     = 1'b0;
        clear      = 1'b0;
        sin        = 1'b0;
        sin_valid  = 1'b0;
        pout_ready = 1'b1;
        #12;
        check("reset_pout", {4'h0, pout}, 8'h0);
        check("reset_valid", {7'h0, pout_valid}, 8'h0);
        check("reset_busy", {7'h0, busy}, 8'h0);
        check("reset_overrun", {7'h0, overrun}, 8'h0);
        check("reset_parity", {7'h0, parity_err}, 8'h0);
        @(negedge clk);
        reset_ = 1'b1;

`ifndef SIPO_PARITY_EN
        // Basic: 1,0,1,0 -> A, valid for one cycle
        vecs.push_back(mk(0, 1, 1, 1, 1, 4'h0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 4'h0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 1, 1, 4'h0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 4'hA, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 4'hA, 0, 0, 0));
        // Gaps: 0,1,1,0 with two idle cycles between bits -> 6
        vecs.push_back(mk(0, 0, 1, 1, 1, 4'hA, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 1, 1, 4'hA, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 1, 1, 4'hA, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 1, 1, 4'hA, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 4'hA, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 4'hA, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 1, 1, 4'hA, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 1, 1, 4'hA, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 1, 1, 4'hA, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 4'h6, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 4'h6, 0, 0, 0));
        // Backpressure: 3 held, 5 dropped, overrun sticky until clear
        vecs.push_back(mk(0, 0, 1, 0, 1, 4'h6, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 4'h6, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 1, 4'h6, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 1, 4'h3, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 4'h3, 1, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 1, 4'h3, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 4'h3, 1, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 1, 4'h3, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 1, 4'h3, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 4'h3, 0, 0, 1));
        vecs.push_back(mk(1, 1, 1, 0, 0, 4'h0, 0, 0, 0));
        // Back-to-back: 3 held, ready with last bit of 9, valid never drops
        vecs.push_back(mk(0, 0, 1, 0, 0, 4'h0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 4'h0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 4'h0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 1, 4'h3, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 1, 4'h3, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 4'h3, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 4'h3, 1, 1, 0));
        vecs.push_back(mk(0, 1, 1, 1, 1, 4'h9, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 4'h9, 0, 0, 0));
        // No parity: 1,0,1,1 then a 5th bit starts a new word (1,0,0,0 -> 8)
        vecs.push_back(mk(0, 1, 1, 1, 1, 4'h9, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 4'h9, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 1, 1, 4'h9, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 1, 1, 4'hB, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 1, 4'hB, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 4'hB, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 4'hB, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 4'h8, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 4'h8, 0, 0, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].clr, vecs[i].sin, vecs[i].sv, vecs[i].rdy);
            if (vecs[i].chk_pout) check($sformatf("v%0d_pout", i), {4'h0, pout}, {4'h0, vecs[i].pout});
            check($sformatf("v%0d_valid", i), {7'h0, pout_valid}, {7'h0, vecs[i].pv});
            check($sformatf("v%0d_busy", i), {7'h0, busy}, {7'h0, vecs[i].busy});
            check($sformatf("v%0d_overrun", i), {7'h0, overrun}, {7'h0, vecs[i].ovr});
            check($sformatf("v%0d_parity", i), {7'h0, parity_err}, 8'h0);
        end

        // Abort by async reset after two bits
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        check("abort_rst_busy_pre", {7'h0, busy}, 8'h1);
        @(negedge clk);
        sin_valid = 1'b0;
        reset_    = 1'b0;
        #1;
        check("abort_rst_pout", {4'h0, pout}, 8'h0);
        check("abort_rst_valid", {7'h0, pout_valid}, 8'h0);
        check("abort_rst_busy", {7'h0, busy}, 8'h0);
        check("abort_rst_overrun", {7'h0, overrun}, 8'h0);
        @(negedge clk);
        reset_ = 1'b1;
        send_word(4'hB, 1'b1);
        check("abort_rst_word", {4'h0, pout}, 8'h0B);
        check("abort_rst_word_valid", {7'h0, pout_valid}, 8'h1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);

        // Abort by clear after two bits; sin is ignored while clear is high
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        check("abort_clr_busy", {7'h0, busy}, 8'h0);
        check("abort_clr_valid", {7'h0, pout_valid}, 8'h0);
        send_word(4'hB, 1'b1);
        check("abort_clr_word", {4'h0, pout}, 8'h0B);
        check("abort_clr_word_valid", {7'h0, pout_valid}, 8'h1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
`else
        // Parity build: data 1,0,1,1 with good then bad even parity
        send_word(4'hB, 1'b1);
        check("par_busy_before_pbit", {7'h0, busy}, 8'h1);
        check("par_valid_before_pbit", {7'h0, pout_valid}, 8'h0);
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        check("par_good_word", {4'h0, pout}, 8'h0B);
        check("par_good_valid", {7'h0, pout_valid}, 8'h1);
        check("par_good_err", {7'h0, parity_err}, 8'h0);
        check("par_good_busy", {7'h0, busy}, 8'h0);
        send_word(4'hB, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        check("par_bad_word", {4'h0, pout}, 8'h0B);
        check("par_bad_valid", {7'h0, pout_valid}, 8'h1);
        check("par_bad_err", {7'h0, parity_err}, 8'h1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        check("par_drain_valid", {7'h0, pout_valid}, 8'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
